multicast_router_buf: RTL and testbench
=======================================

MULTICAST_ROUTER_BUF -- requirements
Module: multicast_router_buf

Interface
REQ-001 SHALL have parameter PE_COUNT, default 9, number of destination PEs.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, payload width.
REQ-003 SHALL have parameter ID_WIDTH, default 8, tag/PE-ID width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, input FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter CNT_WIDTH, default 16, drop counter width.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port in_val  input  DATA_WIDTH  payload.
REQ-009 SHALL have port tag_id  input  ID_WIDTH  destination tag.
REQ-010 SHALL have port tag_mask  input  ID_WIDTH  don't-care bits of tag_id (1 = ignore bit).
REQ-011 SHALL have port in_valid  input  1  producer offers entry.
REQ-012 SHALL have port in_ready  output  1  router can accept entry.
REQ-013 SHALL have port pe_ids  input  ID_WIDTH x PE_COUNT  assigned PE IDs, quasi-static.
REQ-014 SHALL have port out_vals  output  DATA_WIDTH x PE_COUNT  payload per PE.
REQ-015 SHALL have port out_valids  output  1 x PE_COUNT  per-PE delivery valid.
REQ-016 SHALL have port out_readys  input  1 x PE_COUNT  per-PE accept.
REQ-017 SHALL have port busy  output  1  FIFO non-empty or delivery pending.
REQ-018 SHALL have port drop_count  output  CNT_WIDTH  entries discarded for zero matching PEs.

Function
REQ-019 SHALL push {in_val, tag_id, tag_mask} into the FIFO on any edge where in_valid && in_ready; in_ready SHALL equal !fifo_full (a pop in the same cycle does not raise in_ready).
REQ-020 SHALL keep a two-state FSM: IDLE (no entry held), DELIVER (entry held, pending mask non-zero).
REQ-021 SHALL, in IDLE with FIFO non-empty, pop the head on the next edge, register its payload, and compute pending[i] = ((pe_ids[i] ^ tag_id) & ~tag_mask) == 0, sampling pe_ids at that edge only.
REQ-022 SHALL drive out_vals[i] = held payload for every i, and out_valids[i] = pending[i] while in DELIVER, 0 in IDLE.
REQ-023 SHALL clear pending[i] on each edge where out_valids[i] && out_readys[i]; PEs accept independently, in any order, across any number of cycles.
REQ-024 SHALL, when the last set pending bits are accepted and the FIFO is non-empty, pop and load the next entry on that same edge (stay DELIVER, zero bubble); if the FIFO is empty, go to IDLE.
REQ-025 SHALL, if a loaded entry matches zero PEs, discard it on the load edge without entering DELIVER, increment drop_count (saturating at all-ones), and stay/return to IDLE.
REQ-026 SHALL treat tag_mask all-ones as broadcast to all PEs and tag_mask zero as exact-match (multi-match if pe_ids duplicate).
REQ-027 SHALL give minimum latency: entry pushed at edge T is visible on out_valids after edge T+1 when router was IDLE with FIFO empty.
REQ-028 SHALL preserve FIFO order; an entry is never delivered before all targets of the previous entry have accepted.
REQ-029 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with separate full/empty tracking (no lost slot).
REQ-030 SHALL assert busy = !fifo_empty || (state == DELIVER).

Reset
REQ-031 SHALL, while rst is low at an edge, empty the FIFO, enter IDLE, clear pending, held payload and drop_count to 0; in_ready SHALL read 1 and out_valids 0 after reset.
REQ-032 SHALL abandon any partially delivered entry and all buffered entries on reset mid-operation, with no out_valids asserted after the reset edge.

Verification
REQ-033 Unicast: pe_ids = 0..8, push val 0x1234 tag 5 mask 0, all readys 1 -> out_valids only [5] high one cycle after edge T+1, val 0x1234, then IDLE.
REQ-034 Partial accept: tag 0x00 mask 0x03 (PEs 0-3), readys for PE 1,3 low for 3 cycles -> PEs 0,2 drop valid after 1 cycle, PEs 1,3 stay valid until their ready rises; next entry waits.
REQ-035 Back-to-back/full: hold all readys 0, push 5 entries with FIFO_DEPTH 4 -> 1 loaded + 4 buffered, in_ready low on 6th; release readys -> entries delivered in order with no idle cycle between.
REQ-036 Drop: push tag 0xFF mask 0 with no PE ID 0xFF -> no out_valids, drop_count 0->1; 2^CNT_WIDTH+1 such drops -> saturates at all-ones.
REQ-037 Broadcast: mask 0xFF -> all 9 out_valids high simultaneously.
REQ-038 Reset mid-delivery: rst low while DELIVER with 2 FIFO entries -> next cycle out_valids all 0, busy 0, in_ready 1, drop_count 0.

Source files
------------

// File: rtl/multicast_router_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicast_router_buf: FIFO-buffered tag/mask multicast to PE_COUNT PEs   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multicast_router_buf #(
  parameter int unsigned PE_COUNT   = 9,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                in_val,
  input  logic [ID_WIDTH-1:0]                  tag_id,
  input  logic [ID_WIDTH-1:0]                  tag_mask,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PE_COUNT-1:0][ID_WIDTH-1:0]    pe_ids,
  output logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  out_vals,
  output logic [PE_COUNT-1:0]                  out_valids,
  input  logic [PE_COUNT-1:0]                  out_readys,
  output logic                                 busy,
  output logic [CNT_WIDTH-1:0]                 drop_count
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_DELIVER = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   fifo_tag_q  [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   fifo_mask_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  state_t                state_q, state_d;
  logic [PE_COUNT-1:0]   pending_q, pending_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic                  fifo_empty, fifo_full;
  logic                  push, pop, drop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ID_WIDTH-1:0]   head_tag, head_mask;
  logic [PE_COUNT-1:0]   head_match;
  logic [PE_COUNT-1:0]   accepted, remaining;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= in_val;
      fifo_tag_q[wr_ptr_q]  <= tag_id;
      fifo_mask_q[wr_ptr_q] <= tag_mask;
    end
  end

  // Destination set of the FIFO head, evaluated against pe_ids as they stand now.
  always_comb begin
    head_data = fifo_data_q[rd_ptr_q];
    head_tag  = fifo_tag_q[rd_ptr_q];
    head_mask = fifo_mask_q[rd_ptr_q];
    for (int i = 0; i < PE_COUNT; i++) begin
      head_match[i] = (((pe_ids[i] ^ head_tag) & ~head_mask) == '0);
    end
  end

  assign accepted  = (state_q == ST_DELIVER) ? (pending_q & out_readys) : '0;
  assign remaining = pending_q & ~accepted;

  always_comb begin
    state_d      = state_q;
    pending_d    = remaining;
    data_d       = data_q;
    pop          = 1'b0;
    drop         = 1'b0;
    drop_count_d = drop_count_q;

    case (state_q)
      ST_IDLE: begin
        pop = !fifo_empty;
      end
      ST_DELIVER: begin
        if (remaining == '0) begin
          if (fifo_empty) state_d = ST_IDLE;
          else            pop     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading the head; an entry with no destination is discarded right here.
    if (pop) begin
      data_d = head_data;
      if (head_match == '0) begin
        drop      = 1'b1;
        state_d   = ST_IDLE;
        pending_d = '0;
      end else begin
        state_d   = ST_DELIVER;
        pending_d = head_match;
      end
    end

    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_WIDTH'(1);
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      data_q       <= '0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      pending_q    <= pending_d;
      data_q       <= data_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < PE_COUNT; i++) begin
      out_vals[i] = data_q;
    end
  end

  assign out_valids = (state_q == ST_DELIVER) ? pending_q : '0;
  assign busy       = !fifo_empty || (state_q == ST_DELIVER);
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicast_router_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicast_router_buf: directed self-checking bench for the router     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_multicast_router_buf;

  localparam int unsigned PE_COUNT   = 9;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ID_WIDTH   = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_WIDTH  = 4;

  logic                                clk;
  logic                                rst;
  logic [DATA_WIDTH-1:0]               in_val;
  logic [ID_WIDTH-1:0]                 tag_id;
  logic [ID_WIDTH-1:0]                 tag_mask;
  logic                                in_valid;
  logic                                in_ready;
  logic [PE_COUNT-1:0][ID_WIDTH-1:0]   pe_ids;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] out_vals;
  logic [PE_COUNT-1:0]                 out_valids;
  logic [PE_COUNT-1:0]                 out_readys;
  logic                                busy;
  logic [CNT_WIDTH-1:0]                drop_count;

  int n_vec;
  int n_err;

  multicast_router_buf #(
    .PE_COUNT  (PE_COUNT),
    .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH  (ID_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .tag_id    (tag_id),
    .tag_mask  (tag_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pe_ids    (pe_ids),
    .out_vals  (out_vals),
    .out_valids(out_valids),
    .out_readys(out_readys),
    .busy      (busy),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic offer(input logic [15:0] v, input logic [7:0] t, input logic [7:0] m);
    in_val   = v;
    tag_id   = t;
    tag_mask = m;
    in_valid = 1'b1;
  endtask

  logic [PE_COUNT-1:0] seen;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst        = 1'b0;
    in_val     = '0;
    tag_id     = '0;
    tag_mask   = '0;
    in_valid   = 1'b0;
    out_readys = '0;
    for (int i = 0; i < PE_COUNT; i++) pe_ids[i] = 8'(i);

    // Reset state
    cyc(); cyc();
    chk_val("rst_in_ready", 32'(in_ready), 32'h1);
    chk_val("rst_valids", 32'(out_valids), 32'h0);
    chk_val("rst_busy", 32'(busy), 32'h0);
    chk_val("rst_drops", 32'(drop_count), 32'h0);
    rst = 1'b1;
    cyc();

    // Unicast to PE 5
    out_readys = '1;
    offer(16'h1234, 8'h05, 8'h00);
    cyc();
    in_valid = 1'b0;
    chk_val("uni_after_push", 32'(out_valids), 32'h0);
    chk_val("uni_busy", 32'(busy), 32'h1);
    cyc();
    chk_val("uni_valids", 32'(out_valids), 32'h020);
    chk_val("uni_val5", 32'(out_vals[5]), 32'h1234);
    cyc();
    chk_val("uni_done", 32'(out_valids), 32'h0);
    chk_val("uni_idle_busy", 32'(busy), 32'h0);

    // Partial accept: PEs 0-3, PEs 1 and 3 stall
    out_readys = 9'h1F5;
    offer(16'hCAFE, 8'h00, 8'h03);
    cyc();
    offer(16'hBEEF, 8'h06, 8'h00);
    cyc();
    in_valid = 1'b0;
    chk_val("part_load", 32'(out_valids), 32'h00F);
    chk_val("part_val2", 32'(out_vals[2]), 32'hCAFE);
    cyc();
    chk_val("part_stall1", 32'(out_valids), 32'h00A);
    cyc();
    chk_val("part_stall2", 32'(out_valids), 32'h00A);
    out_readys = '1;
    cyc();
    chk_val("part_next", 32'(out_valids), 32'h040);
    chk_val("part_next_val", 32'(out_vals[6]), 32'hBEEF);
    cyc();
    chk_val("part_idle", 32'(out_valids), 32'h0);

    // Back-to-back with FIFO full
    out_readys = '0;
    for (int k = 0; k < 5; k++) begin
      offer(16'hA000 + 16'(k), 8'(k), 8'h00);
      chk_val("full_ready_pre", 32'(in_ready), 32'h1);
      cyc();
    end
    offer(16'hDEAD, 8'h07, 8'h00);
    chk_val("full_sixth_ready", 32'(in_ready), 32'h0);
    cyc();
    chk_val("full_still_full", 32'(in_ready), 32'h0);
    chk_val("full_head", 32'(out_valids), 32'h001);
    in_valid = 1'b0;
    out_readys = '1;
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk_val("full_order", 32'(out_valids), 32'h1 << k);
      chk_val("full_order_val", 32'(out_vals[k]), 32'hA000 + 32'(k));
    end
    cyc();
    chk_val("full_drained", 32'(out_valids), 32'h0);
    chk_val("full_drained_busy", 32'(busy), 32'h0);

    // Drop on no match, then saturation
    seen = '0;
    offer(16'h5555, 8'hFF, 8'h00);
    cyc();
    in_valid = 1'b0;
    seen |= out_valids;
    cyc();
    seen |= out_valids;
    chk_val("drop_one", 32'(drop_count), 32'h1);
    chk_val("drop_busy", 32'(busy), 32'h0);
    offer(16'h5555, 8'hFF, 8'h00);
    for (int k = 0; k < 20; k++) begin
      cyc();
      seen |= out_valids;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      seen |= out_valids;
    end
    chk_val("drop_sat", 32'(drop_count), 32'hF);
    chk_val("drop_no_valids", 32'(seen), 32'h0);

    // Broadcast
    offer(16'h7777, 8'h55, 8'hFF);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk_val("bcast_valids", 32'(out_valids), 32'h1FF);
    chk_val("bcast_val8", 32'(out_vals[8]), 32'h7777);
    cyc();
    chk_val("bcast_done", 32'(out_valids), 32'h0);

    // Reset in the middle of a delivery with two entries buffered
    out_readys = '0;
    offer(16'h0101, 8'h01, 8'h00);
    cyc();
    offer(16'h0202, 8'h02, 8'h00);
    cyc();
    offer(16'h0303, 8'h03, 8'h00);
    cyc();
    in_valid = 1'b0;
    chk_val("mid_valids", 32'(out_valids), 32'h002);
    chk_val("mid_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk_val("mid_rst_valids", 32'(out_valids), 32'h0);
    chk_val("mid_rst_busy", 32'(busy), 32'h0);
    chk_val("mid_rst_ready", 32'(in_ready), 32'h1);
    chk_val("mid_rst_drops", 32'(drop_count), 32'h0);
    out_readys = '1;
    cyc();
    chk_val("mid_rst_flushed", 32'(out_valids), 32'h0);
    chk_val("mid_rst_flushed_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
